wb_sram16_arb: RTL

Dual-port Wishbone slave that shares one external 16-bit async SRAM (sram16 model / DE1 SRAM) between two 32-bit Wishbone masters, e.g. LM32 instruction and data buses. Each 32-bit access is split into two sequenced 16-bit SRAM cycles with programmable wait states. The block drives SRAM address, data, byte enables and strobes, and returns a single-cycle ack to the granted master. It sits between the system bus masters and the sram_* top-level pins.

---
 rtl/wb_sram16_arb.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_sram16_arb.sv
// rtl/wb_sram16_arb.sv - dual Wishbone slave sharing one 16-bit async SRAM
// Each 32-bit access runs as two 16-bit SRAM cycles, upper half first.
// Optional macro SRAM_RR_ARB_EN selects round-robin arbitration
// (default: fixed priority, m0 wins simultaneous requests).
module wb_sram16_arb #(
  parameter int adr_width   = 18,
  parameter int wait_states = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  input  logic                 m0_we_i,
  input  logic [31:0]          m0_adr_i,
  input  logic [3:0]           m0_sel_i,
  input  logic [31:0]          m0_dat_i,
  output logic [31:0]          m0_dat_o,
  output logic                 m0_ack_o,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  input  logic                 m1_we_i,
  input  logic [31:0]          m1_adr_i,
  input  logic [3:0]           m1_sel_i,
  input  logic [31:0]          m1_dat_i,
  output logic [31:0]          m1_dat_o,
  output logic                 m1_ack_o,
  output logic [adr_width-1:0] sram_adr,
  inout  wire  [15:0]          sram_dat,
  output logic                 sram_ub_n,
  output logic                 sram_lb_n,
  output logic                 sram_ce_n,
  output logic                 sram_oe_n,
  output logic                 sram_we_n
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_ACK
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(wait_states);

  state_t               state_q;
  logic                 gnt_q;       // 0 = m0, 1 = m1
  logic                 last_gnt_q;
  logic                 half_q;
  logic [3:0]           cnt_q;
  logic                 we_q;
  logic [3:0]           sel_q;
  logic [31:0]          dat_q;
  logic [adr_width-2:0] wadr_q;
  logic                 drive_q;
  logic [15:0]          wdat_q;

  logic                 req0, req1, pick1, cnt_last, begin_half;
  logic                 bh_we, bh_half, bh_ub_n, bh_lb_n;
  logic [3:0]           bh_sel;
  logic [31:0]          bh_dat;
  logic [15:0]          bh_dat16;
  logic [adr_width-2:0] bh_wadr;

  logic                 unused_ok;
  assign unused_ok = ^{m0_adr_i[31:adr_width+1], m0_adr_i[1:0],
                       m1_adr_i[31:adr_width+1], m1_adr_i[1:0], last_gnt_q};

  assign req0     = m0_cyc_i & m0_stb_i;
  assign req1     = m1_cyc_i & m1_stb_i;
  assign cnt_last = (cnt_q == CNT_LAST);

  // SRAM data bus is only driven by us while a write half is in flight
  assign sram_dat = drive_q ? wdat_q : 16'hzzzz;

  // Winner selection and the parameters of the next 16-bit half to launch
  always_comb begin
`ifdef SRAM_RR_ARB_EN
    pick1 = req1 & (~req0 | ~last_gnt_q);
`else
    pick1 = req1 & ~req0;
`endif
    bh_we   = we_q;
    bh_sel  = sel_q;
    bh_dat  = dat_q;
    bh_wadr = wadr_q;
    bh_half = 1'b1;
    if (state_q == S_IDLE) begin
      bh_half = 1'b0;
      if (pick1) begin
        bh_we   = m1_we_i;
        bh_sel  = m1_sel_i;
        bh_dat  = m1_dat_i;
        bh_wadr = m1_adr_i[adr_width:2];
      end else begin
        bh_we   = m0_we_i;
        bh_sel  = m0_sel_i;
        bh_dat  = m0_dat_i;
        bh_wadr = m0_adr_i[adr_width:2];
      end
    end
    bh_dat16 = bh_half ? bh_dat[15:0] : bh_dat[31:16];
    bh_ub_n  = bh_we ? ~(bh_half ? bh_sel[1] : bh_sel[3]) : 1'b0;
    bh_lb_n  = bh_we ? ~(bh_half ? bh_sel[0] : bh_sel[2]) : 1'b0;
    begin_half = ((state_q == S_IDLE) && (req0 || req1)) ||
                 ((state_q == S_RD) && cnt_last && !half_q) ||
                 ((state_q == S_WR_HOLD) && !half_q);
  end

  // Access sequencer with registered SRAM strobes, read capture and acks
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      last_gnt_q <= 1'b1;
      half_q     <= 1'b0;
      cnt_q      <= 4'd0;
      we_q       <= 1'b0;
      sel_q      <= 4'd0;
      dat_q      <= 32'd0;
      wadr_q     <= '0;
      drive_q    <= 1'b0;
      wdat_q     <= 16'd0;
      sram_adr   <= '0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
      m0_ack_o   <= 1'b0;
      m1_ack_o   <= 1'b0;
      m0_dat_o   <= 32'd0;
      m1_dat_o   <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            gnt_q  <= pick1;
`ifdef SRAM_RR_ARB_EN
            last_gnt_q <= pick1;
`endif
            we_q   <= bh_we;
            sel_q  <= bh_sel;
            dat_q  <= bh_dat;
            wadr_q <= bh_wadr;
          end
        end
        S_RD: begin
          if (cnt_last) begin
            if (gnt_q) begin
              if (half_q) m1_dat_o[15:0] <= sram_dat;
              else        m1_dat_o[31:16] <= sram_dat;
            end else begin
              if (half_q) m0_dat_o[15:0] <= sram_dat;
              else        m0_dat_o[31:16] <= sram_dat;
            end
            if (half_q) begin
              state_q   <= S_ACK;
              sram_ce_n <= 1'b1;
              sram_oe_n <= 1'b1;
              sram_ub_n <= 1'b1;
              sram_lb_n <= 1'b1;
              m0_ack_o  <= ~gnt_q;
              m1_ack_o  <= gnt_q;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_WR_SETUP: begin
          state_q   <= S_WR_PULSE;
          sram_we_n <= 1'b0;
          cnt_q     <= 4'd0;
        end
        S_WR_PULSE: begin
          if (cnt_last) begin
            state_q   <= S_WR_HOLD;
            sram_we_n <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_WR_HOLD: begin
          if (half_q) begin
            state_q   <= S_ACK;
            sram_ce_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
            drive_q   <= 1'b0;
            m0_ack_o  <= ~gnt_q;
            m1_ack_o  <= gnt_q;
          end
        end
        S_ACK: begin
          state_q  <= S_IDLE;
          m0_ack_o <= 1'b0;
          m1_ack_o <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
      // Launching a half overrides the per-state updates above
      if (begin_half) begin
        state_q   <= bh_we ? S_WR_SETUP : S_RD;
        half_q    <= bh_half;
        cnt_q     <= 4'd0;
        sram_adr  <= {bh_wadr, bh_half};
        sram_ce_n <= 1'b0;
        sram_oe_n <= bh_we;
        sram_we_n <= 1'b1;
        sram_ub_n <= bh_ub_n;
        sram_lb_n <= bh_lb_n;
        drive_q   <= bh_we;
        wdat_q    <= bh_dat16;
      end
    end
  end

endmodule
